seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000, clock cycles each digit is enabled; legal range 2 or more.
REQ-002 Parameter BLINK_FRAMES, default 128, frames per blink half-period; present only with SEG_BLINK_EN.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 four_bcd, three_bcd, two_bcd, one_bcd  input  4 each  digit codes, leftmost to rightmost.
REQ-006 blink  input  1  flash-enable request; present only with SEG_BLINK_EN.
REQ-007 an_out  output  4  active-low digit enables; bit 3 is the leftmost digit.
REQ-008 seg_out  output  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.
REQ-009 frame_done  output  1  one-cycle pulse when a full four-digit scan completes.

Function
REQ-010 Divider counts 0..DIGIT_CYCLES-1 and wraps; at terminal count the 2-bit scan index advances 0->1->2->3->0.
REQ-011 Index 0,1,2,3 selects four,three,two,one; an_out = 0111, 1011, 1101, 1110 respectively.
REQ-012 Shadow registers load all four inputs on the edge where divider==0 and index==0; inputs are ignored at all other times (no mid-frame tearing).
REQ-013 an_out and seg_out are registered and reflect the current index and shadow one edge later.
REQ-014 Decode table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, 10 (V)=C1, 11 (-)=BF, 12 (L)=C7, 13 (E)=86, 14 (P)=8C, 15 (blank)=FF; dp is always off.
REQ-015 frame_done is high for exactly one cycle, on the edge where index 3 reaches terminal count; it pulses once every 4*DIGIT_CYCLES cycles.
REQ-016 Exactly one an_out bit is low at any time outside reset and the blink-off phase.

Reset
REQ-017 While rst_n is low, outputs are held immediately, independent of clk: an_out=1111, seg_out=FF, frame_done=0.
REQ-018 Reset values: divider=0, index=0, every shadow register=15 (blank), blink phase=on, frame counter=0.
REQ-019 First edge after release loads the shadow; second edge drives an_out=0111 with the decoded four_bcd value.
REQ-020 Reset asserted mid-scan discards the current frame; the scan restarts from index 0 after release.

Configuration
REQ-021 With macro SEG_BLINK_EN defined: a frame counter counts frame_done pulses while blink=1 and toggles the blink phase every BLINK_FRAMES frames.
REQ-022 During the blink-off phase, an_out is forced to 1111; the scan, shadow and frame_done continue unchanged.
REQ-023 With SEG_BLINK_EN defined, blink=0 clears the frame counter and forces the phase to on within one cycle.
REQ-024 Without SEG_BLINK_EN, the blink port, the BLINK_FRAMES parameter and the related logic are absent, and the display is always on.

Structure
REQ-025 A shared package holds the 16-entry segment pattern constants, the BCD code constants (CODE_V=10, CODE_DASH=11, CODE_L=12, CODE_E=13, CODE_P=14, CODE_BLANK=15) and the an_out one-hot-low patterns.
REQ-026 The decoder is one combinational sub-module, seg_decode (4-bit code in, 8-bit pattern out), and the block contains one instance of it.

Verification (DIGIT_CYCLES=4, BLINK_FRAMES=2)
REQ-027 Reset, then release with inputs 1,2,3,4: an_out/seg_out step through 0111/F9, 1011/A4, 1101/B0, 1110/99, 4 cycles each, then repeat.
REQ-028 Inputs changed 0,0,0,0 -> 7,7,7,7 during index 1: the remainder of the frame still shows 0 (C0); 7 (F8) appears from the next frame's index 0.
REQ-029 Level-screen inputs 12,10,15,2 -> seg_out sequence C7, C1, FF, A4.
REQ-030 frame_done is high for exactly 1 cycle every 16 cycles, coincident with the index 3 -> 0 wrap.
REQ-031 rst_n pulled low mid-digit, between clock edges -> an_out=1111 and seg_out=FF immediately, without waiting for a clock edge.
REQ-032 With SEG_BLINK_EN and blink=1: an_out is 1111 for 2 frames, then scans for 2 frames, alternating; blink=0 restores scanning within 1 cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared codes, segment patterns and digit-enable patterns for seg_scan
package seg_scan_pkg;

    localparam logic [3:0] CODE_V     = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] CODE_L     = 4'd12;
    localparam logic [3:0] CODE_E     = 4'd13;
    localparam logic [3:0] CODE_P     = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low {dp,g,f,e,d,c,b,a}; dp (bit 7) is high in every entry.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hC1, 8'hBF, 8'hC7, 8'h86, 8'h8C, 8'hFF
    };
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [3:0] AN_DIG [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] AN_OFF     = 4'b1111;

    function automatic logic [3:0] an_pattern(input logic [1:0] idx);
        return AN_DIG[idx];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational 4-bit code to active-low segment pattern decoder
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_TABLE[i_code];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit multiplexed seven-segment scanner; SEG_BLINK_EN adds frame-based blinking
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 128
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] four_bcd,
    input  logic [3:0] three_bcd,
    input  logic [3:0] two_bcd,
    input  logic [3:0] one_bcd,
`ifdef SEG_BLINK_EN
    input  logic       blink,
`endif
    output logic [3:0] an_out,
    output logic [7:0] seg_out,
    output logic       frame_done
);

    localparam int DIV_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [3:0]       r_shadow [4];
    logic [3:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_done;

    logic             w_tc;
    logic             w_frame_end;
    logic             w_load;
    logic             w_blank;
    logic [3:0]       w_code;
    logic [7:0]       w_seg;

    assign w_tc        = (r_div == DIV_LAST);
    assign w_frame_end = w_tc && (r_idx == 2'd3);
    assign w_load      = (r_div == '0) && (r_idx == 2'd0);
    assign w_code      = r_shadow[r_idx];

    seg_decode u_seg_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (w_tc) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Shadow captures a whole frame at once so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= CODE_BLANK;
            end
        end else if (w_load) begin
            r_shadow[0] <= four_bcd;
            r_shadow[1] <= three_bcd;
            r_shadow[2] <= two_bcd;
            r_shadow[3] <= one_bcd;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_phase_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_phase_off <= 1'b0;
        end else if (!blink) begin
            r_frame_cnt <= '0;
            r_phase_off <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frame_cnt == CNT_LAST) begin
                r_frame_cnt <= '0;
                r_phase_off <= ~r_phase_off;
            end else begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    // Gating with the live blink level lets a blink drop restore the scan on the next edge.
    assign w_blank = r_phase_off && blink;
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_blank ? AN_OFF : an_pattern(r_idx);
            r_seg        <= w_seg;
            r_frame_done <= w_frame_end;
        end
    end

    assign an_out     = r_an;
    assign seg_out    = r_seg;
    assign frame_done = r_frame_done;

endmodule
